gate_bist_ctrl: RTL and testbench
=================================

# gate_bist_ctrl

Built-in self-test sequencer for a 2-input combinational gate cell (NOR by default). On a start pulse it drives the gate's two inputs through all four input vectors, waits a programmable settle time, samples the gate output and compares it against an expected truth table. It accumulates a mismatch count and reports pass/fail. It sits beside the gate under test and replaces hand-written stimulus sequences in gate benches and silicon bring-up.

## Interface
- TRUTH_TABLE, 4'b0001, expected output; bit i is the output for vector i = {in1,in2}; default is NOR.
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; minimum 1, elaboration error otherwise.
- NUM_ROUNDS, 1, full 4-vector sweeps per run; minimum 1.
- ERR_W, 8, width of err_count.
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- gate_out  input  1  output of the gate under test.
- gate_in1  output  1  gate input 1, registered.
- gate_in2  output  1  gate input 2, registered.
- busy  output  1  run in progress.
- done  output  1  run complete; level, held until next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  ERR_W  mismatches this run, saturating.
- fail_mask  output  4  only with GATE_BIST_FAIL_MASK_EN; bit i set if vector i mismatched in any round.

## Operation
- Decided: one clock; reset is synchronous and active-high, on ports clk and rst.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start → SETTLE. The transition clears err_count and fail_mask, sets the vector index to 0 and the round counter to 0, and drops done.
- SETTLE: lasts SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE: lasts 1 cycle. Compare gate_out with TRUTH_TABLE[idx]; on mismatch, increment err_count, saturating at 2^ERR_W-1. Then:
  - idx<3: idx++ → SETTLE.
  - idx==3 and more rounds remain: idx=0, round++ → SETTLE.
  - otherwise → DONE.
- DONE: done=1; pass valid. start restarts the run; otherwise the FSM holds.
- gate_in1=idx[1] and gate_in2=idx[0] while busy. Both are 0 in IDLE/DONE.
- start during SETTLE/SAMPLE is ignored.
- In simulation, X/Z on gate_out counts as a mismatch (4-state compare).
- Reset values: gate_in1=0, gate_in2=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, state=IDLE.
- rst mid-run aborts at the next edge; no partial result is retained.

## Timing
- start high at edge N → state SETTLE, busy=1, vector 0 applied after edge N.
- Each vector is held SETTLE_CYCLES+1 cycles; gate_out is sampled on the last of them.
- Run length: busy is high for 4·NUM_ROUNDS·(SETTLE_CYCLES+1) cycles, then done=1 and busy=0 on the following cycle.
- Defaults: start at cycle 0 → busy for cycles 1–12 → done at cycle 13.
- err_count/fail_mask update on the edge ending SAMPLE and are stable while done.
- start held high continuously: the block runs back to back, with one DONE cycle between runs.

## Configuration
- GATE_BIST_FAIL_MASK_EN defined: the fail_mask port and its 4-bit sticky register exist, cleared on start and on rst.
- Undefined: the port and register are absent. All other behaviour is identical.

## Structure
- Package gate_bist_pkg contains:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - a 2-bit vector-index typedef;
  - the constants TT_NOR=4'b0001, TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110.
- No sub-module. The settle counter, round counter and FSM are inline in gate_bist_ctrl.
- Benches instantiate the existing nor_gate cell as the gate under test.

## Test plan
- Defaults, healthy NOR, start at cycle 0 → busy cycles 1–12, done=1 at 13, pass=1, err_count=0, fail_mask=4'b0000.
- gate_out stuck at 1 → err_count=3, pass=0, fail_mask=4'b1110.
- TRUTH_TABLE=TT_NAND against a real NOR → err_count=2, fail_mask=4'b0110.
- NUM_ROUNDS=100, ERR_W=6, gate_out stuck at 1 → 300 mismatches; err_count saturates at 63, pass=0.
- rst high at cycle 6 of a default run → the next cycle shows all outputs 0 and IDLE. A start pulse at cycle 3 (while busy) changes nothing.
- start held high through DONE → a second run begins the cycle after done. done drops and err_count clears, with an identical result to the first run.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST sequencer.
// Holds the FSM state encoding, the vector-index type and the
// standard truth tables for common 2-input gates.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Vector index: bit 1 drives gate_in1, bit 0 drives gate_in2.
  typedef logic [1:0] vec_idx_t;

  // Truth tables, bit i = expected output for input vector i = {in1,in2}.
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;

  // True while a sweep is in progress.
  function automatic logic state_is_busy(input state_t s);
    return (s == SETTLE) || (s == SAMPLE);
  endfunction

endpackage

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a 2-input combinational gate.
// Sweeps all four input vectors NUM_ROUNDS times, holding each for
// SETTLE_CYCLES+1 cycles and sampling gate_out on the last one, then
// reports a saturating mismatch count and pass/fail.
// Optional feature macro: GATE_BIST_FAIL_MASK_EN adds the fail_mask port
// (sticky per-vector mismatch flags).
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_NOR,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         NUM_ROUNDS    = 1,
  parameter int         ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gate_out,
  output logic             gate_in1,
  output logic             gate_in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_BIST_FAIL_MASK_EN
  ,
  output logic [3:0]       fail_mask
`endif
);

  // Counter widths; at least one bit even when the count is trivially 1.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  // Reject configurations that cannot produce a meaningful sweep.
  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("gate_bist_ctrl: SETTLE_CYCLES must be at least 1");
    end
    if (NUM_ROUNDS < 1) begin : g_bad_rounds
      $error("gate_bist_ctrl: NUM_ROUNDS must be at least 1");
    end
  endgenerate

  state_t           state_reg, state_next;
  vec_idx_t         idx_reg, idx_next;
  vec_idx_t         idx_inc;
  logic [SET_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [RND_W-1:0] round_reg, round_next;
  logic [ERR_W-1:0] err_reg, err_next;
  logic             in1_reg, in1_next;
  logic             in2_reg, in2_next;
  logic             mismatch;
`ifdef GATE_BIST_FAIL_MASK_EN
  logic [3:0]       mask_reg, mask_next;
`endif

  // 4-state compare so an X/Z on gate_out is counted as a failure in simulation.
  assign mismatch = (gate_out !== TRUTH_TABLE[idx_reg]);

  // State register and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      settle_cnt_reg <= '0;
      round_reg      <= '0;
      err_reg        <= '0;
      in1_reg        <= 1'b0;
      in2_reg        <= 1'b0;
`ifdef GATE_BIST_FAIL_MASK_EN
      mask_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      settle_cnt_reg <= settle_cnt_next;
      round_reg      <= round_next;
      err_reg        <= err_next;
      in1_reg        <= in1_next;
      in2_reg        <= in2_next;
`ifdef GATE_BIST_FAIL_MASK_EN
      mask_reg       <= mask_next;
`endif
    end
  end

  // Next-state logic: sequence settle/sample per vector, advance vector and round.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    idx_inc         = vec_idx_t'(idx_reg + 2'd1);
    settle_cnt_next = settle_cnt_reg;
    round_next      = round_reg;
    err_next        = err_reg;
    in1_next        = in1_reg;
    in2_next        = in2_reg;
`ifdef GATE_BIST_FAIL_MASK_EN
    mask_next       = mask_reg;
`endif

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next      = SETTLE;
          idx_next        = '0;
          settle_cnt_next = '0;
          round_next      = '0;
          err_next        = '0;
          in1_next        = 1'b0;
          in2_next        = 1'b0;
`ifdef GATE_BIST_FAIL_MASK_EN
          mask_next       = '0;
`endif
        end
      end

      SETTLE: begin
        if (settle_cnt_reg == SET_LAST) begin
          state_next      = SAMPLE;
          settle_cnt_next = '0;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          if (err_reg != ERR_MAX) begin
            err_next = err_reg + 1'b1;
          end
`ifdef GATE_BIST_FAIL_MASK_EN
          mask_next[idx_reg] = 1'b1;
`endif
        end
        if (idx_reg != 2'd3) begin
          // Next vector of the current sweep.
          state_next = SETTLE;
          idx_next   = idx_inc;
          in1_next   = idx_inc[1];
          in2_next   = idx_inc[0];
        end else if (round_reg != RND_LAST) begin
          // Start another sweep from vector 0.
          state_next = SETTLE;
          idx_next   = '0;
          round_next = round_reg + 1'b1;
          in1_next   = 1'b0;
          in2_next   = 1'b0;
        end else begin
          state_next = DONE;
          in1_next   = 1'b0;
          in2_next   = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        in1_next   = 1'b0;
        in2_next   = 1'b0;
      end
    endcase
  end

  assign gate_in1  = in1_reg;
  assign gate_in2  = in2_reg;
  assign busy      = state_is_busy(state_reg);
  assign done      = (state_reg == DONE);
  assign pass      = done && (err_reg == '0);
  assign err_count = err_reg;
`ifdef GATE_BIST_FAIL_MASK_EN
  assign fail_mask = mask_reg;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: table-driven full runs on a
// default instance, plus reset-abort, back-to-back, NAND-table and
// saturation sequences on dedicated instances.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Instance A: defaults, gate behaviour selectable for fault injection.
  logic       start_a = 1'b0;
  logic [1:0] mode_a  = 2'd0;
  logic       gout_a, in1_a, in2_a, busy_a, done_a, pass_a;
  logic [7:0] err_a;
  // Instance B: NAND truth table against a real NOR.
  logic       start_b = 1'b0;
  logic       gout_b, in1_b, in2_b, busy_b, done_b, pass_b;
  logic [7:0] err_b;
  // Instance C: 100 rounds, 6-bit counter, gate stuck at 1.
  logic       start_c = 1'b0;
  logic       gout_c, in1_c, in2_c, busy_c, done_c, pass_c;
  logic [5:0] err_c;
`ifdef GATE_BIST_FAIL_MASK_EN
  logic [3:0] mask_a, mask_b, mask_c;
`endif

  // Gate under test for A: 0 healthy NOR, 1 stuck-1, 2 stuck-0, 3 behaves as OR.
  always_comb begin
    gout_a = ~(in1_a | in2_a);
    case (mode_a)
      2'd1: gout_a = 1'b1;
      2'd2: gout_a = 1'b0;
      2'd3: gout_a = in1_a | in2_a;
      default: gout_a = ~(in1_a | in2_a);
    endcase
  end
  assign gout_b = ~(in1_b | in2_b);
  assign gout_c = 1'b1;

  gate_bist_ctrl u_a (
    .clk(clk), .rst(rst), .start(start_a), .gate_out(gout_a),
    .gate_in1(in1_a), .gate_in2(in2_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a)
`ifdef GATE_BIST_FAIL_MASK_EN
    , .fail_mask(mask_a)
`endif
  );

  gate_bist_ctrl #(.TRUTH_TABLE(TT_NAND)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .gate_out(gout_b),
    .gate_in1(in1_b), .gate_in2(in2_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b)
`ifdef GATE_BIST_FAIL_MASK_EN
    , .fail_mask(mask_b)
`endif
  );

  gate_bist_ctrl #(.NUM_ROUNDS(100), .ERR_W(6)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .gate_out(gout_c),
    .gate_in1(in1_c), .gate_in2(in2_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_count(err_c)
`ifdef GATE_BIST_FAIL_MASK_EN
    , .fail_mask(mask_c)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] mode;
    int         exp_err;
    logic       exp_pass;
    logic [3:0] exp_mask;
  } vec_t;

  vec_t vecs[5];

  // One full default run on A with per-cycle trajectory checks.
  task automatic run_a(input int n, input vec_t v);
    vec_idx_t idx_e;
    mode_a = v.mode;
    next_cycle();
    start_a = 1'b1;
    next_cycle();            // cycle 1: first cycle after the start edge
    start_a = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        idx_e = vec_idx_t'((k - 1) / 3);
        check("busy_run", busy_a, 1'b1);
        check("done_run", done_a, 1'b0);
        check("gate_in1", in1_a, idx_e[1]);
        check("gate_in2", in2_a, idx_e[0]);
      end else begin
        check("busy_end", busy_a, 1'b0);
        check("done_end", done_a, 1'b1);
        check("err_count", err_a, v.exp_err);
        check("pass", pass_a, v.exp_pass);
        check("gate_in_idle", {in1_a, in2_a}, 2'b00);
`ifdef GATE_BIST_FAIL_MASK_EN
        check("fail_mask", mask_a, v.exp_mask);
`endif
      end
      next_cycle();
    end
    $display("[TB] run %0d mode=%0d err=%0d pass=%0b", n, v.mode, err_a, pass_a);
  endtask

  initial begin
    int  cyc;
    bit  seen;

    vecs[0] = '{mode: 2'd0, exp_err: 0, exp_pass: 1'b1, exp_mask: 4'b0000};
    vecs[1] = '{mode: 2'd1, exp_err: 3, exp_pass: 1'b0, exp_mask: 4'b1110};
    vecs[2] = '{mode: 2'd2, exp_err: 1, exp_pass: 1'b0, exp_mask: 4'b0001};
    vecs[3] = '{mode: 2'd3, exp_err: 4, exp_pass: 1'b0, exp_mask: 4'b1111};
    vecs[4] = '{mode: 2'd0, exp_err: 0, exp_pass: 1'b1, exp_mask: 4'b0000};

    // Reset state.
    rst = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_err", err_a, 0);
    check("rst_gate_in", {in1_a, in2_a}, 2'b00);
`ifdef GATE_BIST_FAIL_MASK_EN
    check("rst_mask", mask_a, 4'b0000);
`endif
    next_cycle();
    rst = 1'b0;
    $display("[TB] reset released");

    for (int i = 0; i < 5; i++) run_a(i, vecs[i]);

    // Reset mid-run, with an ignored start pulse at cycle 3.
    mode_a = 2'd3;
    start_a = 1'b1;
    next_cycle();            // cycle 1
    start_a = 1'b0;
    next_cycle();            // cycle 2
    next_cycle();            // cycle 3
    start_a = 1'b1;
    next_cycle();            // cycle 4
    start_a = 1'b0;
    @(negedge clk);
    check("midstart_busy", busy_a, 1'b1);
    check("midstart_vec", {in1_a, in2_a}, 2'b01);
    check("midstart_err", err_a, 1);
    next_cycle();            // cycle 5
    next_cycle();            // cycle 6
    rst = 1'b1;
    next_cycle();            // cycle 7
    @(negedge clk);
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    check("abort_pass", pass_a, 1'b0);
    check("abort_err", err_a, 0);
    check("abort_gate_in", {in1_a, in2_a}, 2'b00);
    next_cycle();
    rst = 1'b0;
    $display("[TB] reset abort err=%0d busy=%0b", err_a, busy_a);

    // Start held high: back-to-back runs with one DONE cycle between.
    mode_a = 2'd1;
    next_cycle();
    start_a = 1'b1;
    next_cycle();            // cycle 1
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (k == 13 || k == 26) begin
        check("b2b_done", done_a, 1'b1);
        check("b2b_busy", busy_a, 1'b0);
        check("b2b_err", err_a, 3);
        check("b2b_pass", pass_a, 1'b0);
      end else if (k == 27) begin
        check("b2b_hold_done", done_a, 1'b1);
        check("b2b_hold_err", err_a, 3);
      end else begin
        check("b2b_busy_run", busy_a, 1'b1);
        check("b2b_done_run", done_a, 1'b0);
        if (k == 14) check("b2b_err_clr", err_a, 0);
      end
      next_cycle();
      if (k == 20) start_a = 1'b0;
    end
    $display("[TB] back-to-back err=%0d done=%0b", err_a, done_a);

    // NAND truth table against a NOR gate.
    start_b = 1'b1;
    next_cycle();
    start_b = 1'b0;
    cyc = 0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      cyc++;
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    check("nand_seen", seen, 1'b1);
    check("nand_cycle", cyc, 13);
    check("nand_err", err_b, 2);
    check("nand_pass", pass_b, 1'b0);
`ifdef GATE_BIST_FAIL_MASK_EN
    check("nand_mask", mask_b, 4'b0110);
`endif
    $display("[TB] nand run err=%0d cycle=%0d", err_b, cyc);

    // Saturation: 300 mismatches into a 6-bit counter.
    next_cycle();
    start_c = 1'b1;
    next_cycle();
    start_c = 1'b0;
    cyc = 0;
    seen = 1'b0;
    repeat (1300) begin
      @(negedge clk);
      cyc++;
      if (done_c) begin
        seen = 1'b1;
        break;
      end
    end
    check("sat_seen", seen, 1'b1);
    check("sat_cycle", cyc, 1201);
    check("sat_err", err_c, 63);
    check("sat_pass", pass_c, 1'b0);
`ifdef GATE_BIST_FAIL_MASK_EN
    check("sat_mask", mask_c, 4'b1110);
`endif
    $display("[TB] saturation run err=%0d cycle=%0d", err_c, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
